// File: rtl/decode_stage_pipe.sv
// -----------------------------------------------------------------------------
// decode_stage_pipe
//
// Decode stage between fetch and execute. It contains:
//   - the register bank, with a general write port C and a vector-byte write
//     port V that loads the top VEC_W bits of VEC_REG (lower bits cleared)
//   - the operand-address muxes (A: LINK_REG or Rp, B: VEC_REG or Rs,
//     C: LINK_REG or Rg_WB)
//   - a write-back bypass, so every read returns the post-write value
//   - immediate sign extension (imm16 or imm24)
//   - a registered ID/EX boundary with valid/stall/flush control
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid          decode inputs valid this cycle
//   stall, flush      hold / squash the ID/EX register (flush wins)
//   sel_A/sel_B/sel_C register-address overrides
//   sel_ext           0: imm16, 1: imm24
//   WE_C, WE_V        write enables for ports C and V
//   PCmas4_In         PC+4 from fetch
//   Rp, Rs, Rg_In     source A, source B, destination being decoded
//   Rg_WB, DinC, DinV write-back address/data, vector byte
//   out_valid         ID/EX contents valid
//   PCmas4_Out, Rg_Out, DoA, DoB, immediato, srcA_q, srcB_q
//                     registered ID/EX contents
//   cuarenta          {DoA, top VEC_W bits of DoB}, combinational
// -----------------------------------------------------------------------------
module decode_stage_pipe #(
    parameter int DATA_W   = 32,
    parameter int NREG     = 16,
    parameter int ADDR_W   = 4,
    parameter int VEC_W    = 8,
    parameter int LINK_REG = 14,
    parameter int VEC_REG  = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      sel_A,
    input  logic                      sel_B,
    input  logic                      sel_C,
    input  logic                      sel_ext,
    input  logic                      WE_C,
    input  logic                      WE_V,
    input  logic [DATA_W-1:0]         PCmas4_In,
    input  logic [ADDR_W-1:0]         Rp,
    input  logic [ADDR_W-1:0]         Rs,
    input  logic [ADDR_W-1:0]         Rg_In,
    input  logic [ADDR_W-1:0]         Rg_WB,
    input  logic [15:0]               imm16,
    input  logic [23:0]               imm24,
    input  logic [DATA_W-1:0]         DinC,
    input  logic [VEC_W-1:0]          DinV,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         PCmas4_Out,
    output logic [ADDR_W-1:0]         Rg_Out,
    output logic [DATA_W-1:0]         DoA,
    output logic [DATA_W-1:0]         DoB,
    output logic [DATA_W+VEC_W-1:0]   cuarenta,
    output logic [DATA_W-1:0]         immediato,
    output logic [ADDR_W-1:0]         srcA_q,
    output logic [ADDR_W-1:0]         srcB_q
);

    localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] VEC_ADDR  = ADDR_W'(VEC_REG);

    logic [DATA_W-1:0] regs [NREG];

    logic [ADDR_W-1:0] dir_a;
    logic [ADDR_W-1:0] dir_b;
    logic [ADDR_W-1:0] dir_c;
    logic [DATA_W-1:0] vec_word;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] refresh_a;
    logic [DATA_W-1:0] refresh_b;
    logic              hit_a;
    logic              hit_b;
    logic [DATA_W-1:0] imm_ext;

    // -------------------------------------------------------------------------
    // Helpers: does a write land on 'addr' this cycle, and what value does a
    // read of 'addr' see after this cycle's writes (C beats V beats storage).
    // -------------------------------------------------------------------------
    function automatic logic write_hit(
        input logic [ADDR_W-1:0] addr,
        input logic              we_c,
        input logic [ADDR_W-1:0] addr_c,
        input logic              we_v
    );
        return (we_c && (addr_c == addr)) || (we_v && (addr == VEC_ADDR));
    endfunction

    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we_c,
        input logic [ADDR_W-1:0] addr_c,
        input logic [DATA_W-1:0] din_c,
        input logic              we_v,
        input logic [DATA_W-1:0] vec_val
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (we_c && (addr_c == addr)) begin
            val = din_c;
        end else if (we_v && (addr == VEC_ADDR)) begin
            val = vec_val;
        end
        return val;
    endfunction

    // -------------------------------------------------------------------------
    // Address muxes and vector-word formation
    // -------------------------------------------------------------------------
    assign dir_a    = sel_A ? LINK_ADDR : Rp;
    assign dir_b    = sel_B ? VEC_ADDR  : Rs;
    assign dir_c    = sel_C ? LINK_ADDR : Rg_WB;
    assign vec_word = {DinV, {(DATA_W-VEC_W){1'b0}}};

    // -------------------------------------------------------------------------
    // Register bank
    // -------------------------------------------------------------------------
    // Port C is written after port V, so when both target VEC_REG the later
    // non-blocking assignment (port C) is the one that sticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (WE_V) begin
                regs[VEC_ADDR] <= vec_word;
            end
            if (WE_C) begin
                regs[dir_c] <= DinC;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Bypassed reads: fresh decode operands and stall-time refresh of the
    // operands already held in ID/EX.
    // -------------------------------------------------------------------------
    always_comb begin
        rd_a      = bypass_read(dir_a,  regs[dir_a],  WE_C, dir_c, DinC, WE_V, vec_word);
        rd_b      = bypass_read(dir_b,  regs[dir_b],  WE_C, dir_c, DinC, WE_V, vec_word);
        refresh_a = bypass_read(srcA_q, regs[srcA_q], WE_C, dir_c, DinC, WE_V, vec_word);
        refresh_b = bypass_read(srcB_q, regs[srcB_q], WE_C, dir_c, DinC, WE_V, vec_word);
        hit_a     = write_hit(srcA_q, WE_C, dir_c, WE_V);
        hit_b     = write_hit(srcB_q, WE_C, dir_c, WE_V);
    end

    // -------------------------------------------------------------------------
    // Immediate extension
    // -------------------------------------------------------------------------
    always_comb begin
        if (sel_ext) begin
            imm_ext = {{(DATA_W-24){imm24[23]}}, imm24};
        end else begin
            imm_ext = {{(DATA_W-16){imm16[15]}}, imm16};
        end
    end

    // -------------------------------------------------------------------------
    // ID/EX boundary: rst > flush > stall > capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid  <= 1'b0;
            PCmas4_Out <= '0;
            Rg_Out     <= '0;
            DoA        <= '0;
            DoB        <= '0;
            immediato  <= '0;
            srcA_q     <= '0;
            srcB_q     <= '0;
        end else if (stall) begin
            // Held operands must not go stale when write-back lands on the
            // registers they were read from.
            if (hit_a) begin
                DoA <= refresh_a;
            end
            if (hit_b) begin
                DoB <= refresh_b;
            end
        end else begin
            out_valid  <= in_valid;
            PCmas4_Out <= PCmas4_In;
            Rg_Out     <= Rg_In;
            DoA        <= rd_a;
            DoB        <= rd_b;
            immediato  <= imm_ext;
            srcA_q     <= dir_a;
            srcB_q     <= dir_b;
        end
    end

    assign cuarenta = {DoA, DoB[DATA_W-1 -: VEC_W]};

endmodule

// File: tb/tb_decode_stage_pipe.sv
module tb_decode_stage_pipe;

    typedef struct packed {
        logic        rst;
        logic        in_valid;
        logic        stall;
        logic        flush;
        logic        sel_A;
        logic        sel_B;
        logic        sel_C;
        logic        sel_ext;
        logic        WE_C;
        logic        WE_V;
        logic [31:0] PCmas4_In;
        logic [3:0]  Rp;
        logic [3:0]  Rs;
        logic [3:0]  Rg_In;
        logic [3:0]  Rg_WB;
        logic [15:0] imm16;
        logic [23:0] imm24;
        logic [31:0] DinC;
        logic [7:0]  DinV;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  rg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [3:0]  sa;
        logic [3:0]  sb;
    } out_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, stall, flush, sel_A, sel_B, sel_C, sel_ext, WE_C, WE_V;
    logic [31:0] PCmas4_In, DinC;
    logic [3:0]  Rp, Rs, Rg_In, Rg_WB;
    logic [15:0] imm16;
    logic [23:0] imm24;
    logic [7:0]  DinV;
    logic        out_valid;
    logic [31:0] PCmas4_Out, DoA, DoB, immediato;
    logic [3:0]  Rg_Out, srcA_q, srcB_q;
    logic [39:0] cuarenta;

    int errors = 0;
    int checks = 0;

    out_t        exp_q[$];
    logic [31:0] mem [16];
    out_t        cur;

    always #5 clk = ~clk;

    decode_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
        .sel_A(sel_A), .sel_B(sel_B), .sel_C(sel_C), .sel_ext(sel_ext),
        .WE_C(WE_C), .WE_V(WE_V), .PCmas4_In(PCmas4_In), .Rp(Rp), .Rs(Rs),
        .Rg_In(Rg_In), .Rg_WB(Rg_WB), .imm16(imm16), .imm24(imm24),
        .DinC(DinC), .DinV(DinV), .out_valid(out_valid), .PCmas4_Out(PCmas4_Out),
        .Rg_Out(Rg_Out), .DoA(DoA), .DoB(DoB), .cuarenta(cuarenta),
        .immediato(immediato), .srcA_q(srcA_q), .srcB_q(srcB_q)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst       = ($urandom_range(99) < 2);
        s.in_valid  = $urandom_range(1);
        s.stall     = ($urandom_range(99) < 25);
        s.flush     = ($urandom_range(99) < 8);
        s.sel_A     = ($urandom_range(99) < 20);
        s.sel_B     = ($urandom_range(99) < 20);
        s.sel_C     = ($urandom_range(99) < 20);
        s.sel_ext   = $urandom_range(1);
        s.WE_C      = $urandom_range(1);
        s.WE_V      = ($urandom_range(99) < 30);
        s.PCmas4_In = $urandom;
        s.Rp        = 4'($urandom_range(15));
        s.Rs        = 4'($urandom_range(15));
        s.Rg_In     = 4'($urandom_range(15));
        s.Rg_WB     = 4'($urandom_range(15));
        s.imm16     = 16'($urandom);
        s.imm24     = 24'($urandom);
        s.DinC      = $urandom;
        s.DinV      = 8'($urandom);
        return s;
    endfunction

    // Drives one cycle of stimulus and records what ID/EX must hold after
    // the following rising edge. The model treats the bank as an array that
    // is updated first (vector write, then general write on top), and every
    // read simply looks at the updated array.
    task automatic step(input stim_t s);
        logic [31:0] nm [16];
        logic [3:0]  addr_c;
        logic [3:0]  a_addr, b_addr;
        @(negedge clk);
        rst = s.rst; in_valid = s.in_valid; stall = s.stall; flush = s.flush;
        sel_A = s.sel_A; sel_B = s.sel_B; sel_C = s.sel_C; sel_ext = s.sel_ext;
        WE_C = s.WE_C; WE_V = s.WE_V; PCmas4_In = s.PCmas4_In;
        Rp = s.Rp; Rs = s.Rs; Rg_In = s.Rg_In; Rg_WB = s.Rg_WB;
        imm16 = s.imm16; imm24 = s.imm24; DinC = s.DinC; DinV = s.DinV;

        addr_c = s.sel_C ? 4'd14 : s.Rg_WB;
        nm = mem;
        if (s.WE_V) nm[15] = {s.DinV, 24'h0};
        if (s.WE_C) nm[addr_c] = s.DinC;

        if (s.rst) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'h0;
            cur = '0;
        end else begin
            if (s.flush) begin
                cur = '0;
            end else if (s.stall) begin
                if ((s.WE_C && addr_c == cur.sa) || (s.WE_V && cur.sa == 4'd15)) cur.a = nm[cur.sa];
                if ((s.WE_C && addr_c == cur.sb) || (s.WE_V && cur.sb == 4'd15)) cur.b = nm[cur.sb];
            end else begin
                a_addr    = s.sel_A ? 4'd14 : s.Rp;
                b_addr    = s.sel_B ? 4'd15 : s.Rs;
                cur.valid = s.in_valid;
                cur.pc    = s.PCmas4_In;
                cur.rg    = s.Rg_In;
                cur.a     = nm[a_addr];
                cur.b     = nm[b_addr];
                cur.imm   = s.sel_ext ? 32'($signed(s.imm24)) : 32'($signed(s.imm16));
                cur.sa    = a_addr;
                cur.sb    = b_addr;
            end
            mem = nm;
        end
        exp_q.push_back(cur);
    endtask

    // Monitor: compares the DUT's ID/EX contents against the oldest expected
    // record one delta after each rising edge.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_valid",  64'(out_valid),  64'(e.valid));
                chk("PCmas4_Out", 64'(PCmas4_Out), 64'(e.pc));
                chk("Rg_Out",     64'(Rg_Out),     64'(e.rg));
                chk("DoA",        64'(DoA),        64'(e.a));
                chk("DoB",        64'(DoB),        64'(e.b));
                chk("immediato",  64'(immediato),  64'(e.imm));
                chk("srcA_q",     64'(srcA_q),     64'(e.sa));
                chk("srcB_q",     64'(srcB_q),     64'(e.sb));
                chk("cuarenta",   64'(cuarenta),   64'({e.a, e.b[31:24]}));
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        sel_A = 1'b0; sel_B = 1'b0; sel_C = 1'b0; sel_ext = 1'b0;
        WE_C = 1'b0; WE_V = 1'b0; PCmas4_In = '0; Rp = '0; Rs = '0;
        Rg_In = '0; Rg_WB = '0; imm16 = '0; imm24 = '0; DinC = '0; DinV = '0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        cur = '0;

        // Reset with writes and capture requested: everything stays zero.
        s = rand_stim(); s.rst = 1'b1; s.WE_C = 1'b1; s.in_valid = 1'b1; step(s);
        // Read after reset.
        s = idle(); s.in_valid = 1'b1; s.Rp = 4'd3; s.PCmas4_In = 32'h104; step(s);
        // Same-cycle general write bypass.
        s = idle(); s.in_valid = 1'b1; s.WE_C = 1'b1; s.Rg_WB = 4'd5;
        s.DinC = 32'hDEADBEEF; s.Rp = 4'd5; step(s);
        // Vector write with sel_B.
        s = idle(); s.in_valid = 1'b1; s.WE_V = 1'b1; s.DinV = 8'hA5; s.sel_B = 1'b1; step(s);
        // C and V both on VEC_REG: port C wins.
        s = idle(); s.in_valid = 1'b1; s.WE_V = 1'b1; s.DinV = 8'h3C; s.sel_B = 1'b1;
        s.WE_C = 1'b1; s.Rg_WB = 4'd15; s.DinC = 32'h12345678; step(s);
        // Capture Rs=7 while writing reg7=1, then stall with reg7=0x99.
        s = idle(); s.in_valid = 1'b1; s.Rs = 4'd7; s.WE_C = 1'b1; s.Rg_WB = 4'd7;
        s.DinC = 32'h1; s.PCmas4_In = 32'h200; s.Rg_In = 4'd9; step(s);
        s = idle(); s.stall = 1'b1; s.WE_C = 1'b1; s.Rg_WB = 4'd7; s.DinC = 32'h99;
        s.PCmas4_In = 32'h300; s.Rg_In = 4'd2; step(s);
        // Stall and flush together, with a write to reg9 that must still land.
        s = idle(); s.stall = 1'b1; s.flush = 1'b1; s.in_valid = 1'b1;
        s.WE_C = 1'b1; s.Rg_WB = 4'd9; s.DinC = 32'h55; step(s);
        s = idle(); s.in_valid = 1'b1; s.Rp = 4'd9; step(s);
        // Immediates and LINK_REG read via sel_C write then sel_A read.
        s = idle(); s.in_valid = 1'b1; s.imm16 = 16'h8001; s.sel_ext = 1'b0;
        s.WE_C = 1'b1; s.sel_C = 1'b1; s.DinC = 32'hCAFE0014; step(s);
        s = idle(); s.in_valid = 1'b1; s.imm24 = 24'h7FFFFF; s.sel_ext = 1'b1;
        s.sel_A = 1'b1; step(s);

        for (int n = 0; n < 3000; n++) begin
            step(rand_stim());
        end

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
